// File: rtl/pipeline_sequencer_if.sv
// Pipeline-control bundle between the hazard/memory sources and the sequencer.
// The master side is the sequencer; the slave side is the datapath that consumes its enables.
interface pipeline_sequencer_if;
    logic       ihit;
    logic       dhit;
    logic       dmemREN_EX_MEM;
    logic       dmemWEN_EX_MEM;
    logic       memRead_ID_EX;
    logic [4:0] Rt_ID_EX;
    logic [4:0] Rs_IF_ID;
    logic [4:0] Rt_IF_ID;
    logic       branch_taken_EX;
    logic       halt_MEM;

    logic       pc_en;
    logic       en_IF_ID;
    logic       en_ID_EX;
    logic       en_EX_MEM;
    logic       en_MEM_WB;
    logic       flush_IF_ID;
    logic       flush_ID_EX;
    logic       dmem_req_en;
    logic       halt;

    modport master (
        input  ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, memRead_ID_EX,
               Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX, halt_MEM,
        output pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
               flush_IF_ID, flush_ID_EX, dmem_req_en, halt
    );

    modport slave (
        output ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, memRead_ID_EX,
               Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX, halt_MEM,
        input  pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
               flush_IF_ID, flush_ID_EX, dmem_req_en, halt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline controller: memory-wait freeze, load-use bubble, branch squash, halt drain.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 1,
    parameter int unsigned PERF_W       = 32
) (
    input  logic                      CLK,
    input  logic                      nRST,
    pipeline_sequencer_if.master      bus,
    output logic [1:0]                state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]         stall_cnt,
    output logic [PERF_W-1:0]         flush_cnt
`endif
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

    if (DRAIN_CYCLES < 1 || PERF_W < 1) begin : g_bad_param
        $error("pipeline_sequencer: DRAIN_CYCLES and PERF_W must be >= 1");
    end

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             lat_q, lat_d;

    logic mem_op, mem_ok, adv, load_use;
    logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic flush_if_id, flush_id_ex, dmem_req_en, halt;
    logic stall_evt;

    always_comb begin
        mem_op   = bus.dmemREN_EX_MEM | bus.dmemWEN_EX_MEM;
        // A data access completed in an earlier frozen cycle still counts as done.
        mem_ok   = ~mem_op | bus.dhit | lat_q;
        adv      = bus.ihit & mem_ok;
        load_use = bus.memRead_ID_EX & (bus.Rt_ID_EX != 5'd0) &
                   ((bus.Rt_ID_EX == bus.Rs_IF_ID) | (bus.Rt_ID_EX == bus.Rt_IF_ID));
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        lat_d       = lat_q;
        pc_en       = 1'b0;
        en_if_id    = 1'b0;
        en_id_ex    = 1'b0;
        en_ex_mem   = 1'b0;
        en_mem_wb   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        dmem_req_en = 1'b0;
        halt        = 1'b0;
        stall_evt   = 1'b0;

        case (state_q)
            S_RUN: begin
                dmem_req_en = ~lat_q;
                if (adv) begin
                    lat_d = 1'b0;
                end else if (bus.dhit) begin
                    lat_d = 1'b1;
                end

                if (!adv) begin
                    stall_evt = 1'b1;
                end else if (bus.halt_MEM) begin
                    en_mem_wb = 1'b1;
                    state_d   = S_DRAIN;
                    drain_d   = DRAIN_INIT;
                end else if (bus.branch_taken_EX) begin
                    pc_en       = 1'b1;
                    en_if_id    = 1'b1;
                    en_id_ex    = 1'b1;
                    en_ex_mem   = 1'b1;
                    en_mem_wb   = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID; ID/EX loads a bubble while older stages move on.
                    en_id_ex    = 1'b1;
                    en_ex_mem   = 1'b1;
                    en_mem_wb   = 1'b1;
                    flush_id_ex = 1'b1;
                    stall_evt   = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    en_if_id  = 1'b1;
                    en_id_ex  = 1'b1;
                    en_ex_mem = 1'b1;
                    en_mem_wb = 1'b1;
                end
            end
            S_DRAIN: begin
                en_mem_wb = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_HALTED: begin
                halt = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_RUN;
            drain_q <= '0;
            lat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            lat_q   <= lat_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.en_IF_ID    = en_if_id;
    assign bus.en_ID_EX    = en_id_ex;
    assign bus.en_EX_MEM   = en_ex_mem;
    assign bus.en_MEM_WB   = en_mem_wb;
    assign bus.flush_IF_ID = flush_if_id;
    assign bus.flush_ID_EX = flush_id_ex;
    assign bus.dmem_req_en = dmem_req_en;
    assign bus.halt        = halt;
    assign state_o         = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_q, flush_q;

    // Both counters saturate; HALTED produces no events so they hold there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_if_id && flush_q != '1) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_stall;
    assign unused_stall = stall_evt;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer (DRAIN_CYCLES=2) with hand-computed control vectors.
module tb_pipeline_sequencer;

    logic       CLK;
    logic       nRST;
    logic [1:0] state_o;
    int         checks;
    int         errors;

    pipeline_sequencer_if bus();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    pipeline_sequencer #(.DRAIN_CYCLES(2), .PERF_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus), .state_o(state_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    pipeline_sequencer #(.DRAIN_CYCLES(2), .PERF_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus), .state_o(state_o)
    );
`endif

    // Vector order: pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, dmem_req_en, halt
    localparam logic [8:0] V_RUN      = 9'b1_1111_00_1_0;
    localparam logic [8:0] V_RUN_NREQ = 9'b1_1111_00_0_0;
    localparam logic [8:0] V_FRZ      = 9'b0_0000_00_1_0;
    localparam logic [8:0] V_FRZ_LAT  = 9'b0_0000_00_0_0;
    localparam logic [8:0] V_LDUSE    = 9'b0_0011_01_1_0;
    localparam logic [8:0] V_BRANCH   = 9'b1_1111_11_1_0;
    localparam logic [8:0] V_HALT_RUN = 9'b0_0001_00_1_0;
    localparam logic [8:0] V_DRAIN    = 9'b0_0001_00_0_0;
    localparam logic [8:0] V_HALTED   = 9'b0_0000_00_0_1;
    // en_ID_EX is a don't-care while flush_ID_EX is asserted.
    localparam logic [8:0] M_LDUSE    = 9'b1_1011_11_1_1;

    logic [8:0] out_vec;
    assign out_vec = {bus.pc_en, bus.en_IF_ID, bus.en_ID_EX, bus.en_EX_MEM, bus.en_MEM_WB,
                      bus.flush_IF_ID, bus.flush_ID_EX, bus.dmem_req_en, bus.halt};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic ihit, input logic dhit, input logic ren, input logic wen,
                          input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                          input logic [4:0] rt_id, input logic br, input logic hm);
        bus.ihit            = ihit;
        bus.dhit            = dhit;
        bus.dmemREN_EX_MEM  = ren;
        bus.dmemWEN_EX_MEM  = wen;
        bus.memRead_ID_EX   = mr;
        bus.Rt_ID_EX        = rt_ex;
        bus.Rs_IF_ID        = rs_id;
        bus.Rt_IF_ID        = rt_id;
        bus.branch_taken_EX = br;
        bus.halt_MEM        = hm;
    endtask

    // Called at a negedge with inputs already applied; checks, then crosses one posedge.
    task automatic step(input string tag, input logic [8:0] exp, input logic [8:0] mask);
        #1;
        check(tag, {23'd0, out_vec & mask}, {23'd0, exp & mask});
        @(negedge CLK);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nRST   = 1'b0;
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("reset_state", {30'd0, state_o}, 32'd0);
        check("reset_outs", {23'd0, out_vec}, {23'd0, V_FRZ});
        nRST = 1'b1;
        @(negedge CLK);

        // Free run
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 5; i++) step("free_run", V_RUN, 9'h1FF);

        // Data miss on a load: three frozen cycles then advance
        set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) step("dmiss_freeze", V_FRZ, 9'h1FF);
        set_in(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("dmiss_adv", V_RUN, 9'h1FF);

        // Data done before fetch: latch suppresses re-issue until advance
        set_in(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("lat_set", V_FRZ, 9'h1FF);
        set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("lat_hold1", V_FRZ_LAT, 9'h1FF);
        step("lat_hold2", V_FRZ_LAT, 9'h1FF);
        set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("lat_adv", V_RUN_NREQ, 9'h1FF);
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("lat_clear", V_RUN, 9'h1FF);

        // Store miss also freezes
        set_in(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("store_miss", V_FRZ, 9'h1FF);
        set_in(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("store_hit", V_RUN, 9'h1FF);

        // Hazards
        set_in(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        step("lduse_rs", V_LDUSE, M_LDUSE);
        set_in(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        step("branch_over_lduse", V_BRANCH, 9'h1FF);
        set_in(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0);
        step("lduse_rt", V_LDUSE, M_LDUSE);
        set_in(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        step("lduse_r0", V_RUN, 9'h1FF);
        set_in(1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 0);
        step("no_memread", V_RUN, 9'h1FF);
        set_in(1, 0, 0, 0, 1, 5'd9, 5'd3, 5'd4, 0, 0);
        step("lduse_nomatch", V_RUN, 9'h1FF);
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
        step("freeze_over_branch", V_FRZ, 9'h1FF);

        // Simultaneous dhit/ihit: latch must stay clear
        set_in(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("both_hit", V_RUN, 9'h1FF);
        set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("both_hit_nolat", V_FRZ, 9'h1FF);

        // Halt and drain (DRAIN_CYCLES=2 -> three MEM/WB cycles)
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
        step("halt_run", V_HALT_RUN, 9'h1FF);
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("drain_state", {30'd0, state_o}, 32'd1);
        step("drain1", V_DRAIN, 9'h1FF);
        step("drain2", V_DRAIN, 9'h1FF);
        check("halted_state", {30'd0, state_o}, 32'd2);
        step("halted1", V_HALTED, 9'h1FF);
        set_in(1, 1, 1, 0, 1, 5'd5, 5'd5, 5'd5, 1, 1);
        step("halted_sticky1", V_HALTED, 9'h1FF);
        step("halted_sticky2", V_HALTED, 9'h1FF);

        // Reset mid-drain
        nRST = 1'b0;
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("halt_run2", V_HALT_RUN, 9'h1FF);
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        #1;
        check("drain_state2", {30'd0, state_o}, 32'd1);
        nRST = 1'b0;
        #1;
        check("rst_drain_state", {30'd0, state_o}, 32'd0);
        check("rst_drain_outs", {23'd0, out_vec}, {23'd0, V_RUN});
        @(negedge CLK);
        nRST = 1'b1;
        step("after_rst", V_RUN, 9'h1FF);

`ifdef PIPE_PERF_CNT_EN
        nRST = 1'b0;
        #1;
        check("perf_rst_stall", stall_cnt, 32'd0);
        check("perf_rst_flush", flush_cnt, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) step("perf_freeze", V_FRZ, 9'h1FF);
        #1;
        check("perf_stall3", stall_cnt, 32'd3);
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
        step("perf_branch", V_BRANCH, 9'h1FF);
        #1;
        check("perf_flush1", flush_cnt, 32'd1);
        check("perf_stall_hold", stall_cnt, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
